// File: rtl/io_ctrl.sv
`default_nettype none
// == io_ctrl : CPU address decode, control register (CR) and wait-state generation -- rev 1.0 ==

module io_ctrl #(
  parameter int NUM_PORTS  = 4,
  parameter int ROM_WAIT   = 2,
  parameter int IO_WAIT    = 1,
  parameter int RAMH_BANKS = 5
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [15:0]          a,
  input  logic                 n_oe,
  input  logic                 n_we,
  input  logic [7:0]           d_in,
  output logic [7:0]           d_out,
  output logic                 d_oe,
  output logic                 n_rdy,
  output logic                 n_rom_cs,
  output logic                 n_raml_cs,
  output logic                 n_ramh_cs,
  output logic [NUM_PORTS-1:0] n_port_oe,
  output logic [NUM_PORTS-1:0] port_cp,
  output logic [7:0]           cr
);

  localparam logic [3:0] C_ROM_W = 4'(ROM_WAIT);
  localparam logic [3:0] C_IO_W  = 4'(IO_WAIT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q;
  logic [3:0]           cnt_q;
  logic                 active_q;
  logic [15:0]          a_q;
  logic [7:0]           cr_q;
  logic [7:0]           cr_d;

  logic [2:0]           win;
  logic [2:0]           port_idx;
  logic [7:0]           win_en;
  logic                 io_page;
  logic                 sel_rom;
  logic                 sel_raml;
  logic                 sel_ramh;
  logic                 sel_cr;
  logic                 sel_ext;
  logic [NUM_PORTS-1:0] sel_port;
  logic [3:0]           wait_w;
  logic                 rd;
  logic                 wr;
  logic                 active;
  logic                 start;

  assign win      = a[14:12];
  assign port_idx = a[3:1];
  assign io_page  = (a[15:8] == 8'hFF);

  // A simultaneous read and write strobe is a write.
  assign wr     = ~n_we;
  assign rd     = ~n_oe & n_we;
  assign active = ~n_oe | ~n_we;
  assign start  = active & (~active_q | (a != a_q));

  // Windows 0/1 are fixed; 2..1+RAMH_BANKS are switched by cr[w+1]; window 7 never maps RAM.
  always_comb begin
    win_en = 8'b0000_0011;
    for (int k = 2; k <= 6; k++) begin
      win_en[k] = (k - 2 < RAMH_BANKS) & cr_q[k+1];
    end
  end

  always_comb begin
    sel_port = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      sel_port[i] = io_page & (int'(port_idx) == i + 1);
    end
  end

  assign sel_ext  = |sel_port;
  assign sel_cr   = io_page & (port_idx == 3'd0);
  assign sel_rom  = ~a[15] & ~cr_q[0];
  assign sel_raml = ~a[15] & cr_q[0];
  assign sel_ramh = a[15] & win_en[win];

  assign n_rom_cs  = ~sel_rom;
  assign n_raml_cs = ~sel_raml;
  assign n_ramh_cs = ~sel_ramh;
  assign n_port_oe = ~(sel_port & {NUM_PORTS{rd}});
  assign port_cp   = ~(sel_port & {NUM_PORTS{wr}});

  assign d_oe  = sel_cr & rd;
  assign d_out = d_oe ? cr_q : 8'h00;
  assign cr    = cr_q;

  assign wait_w = sel_rom ? C_ROM_W : (sel_ext ? C_IO_W : 4'd0);

  // Ready is combinational so an aborted or reset access releases the bus at once.
  always_comb begin
    n_rdy = 1'b0;
    if (n_rst && active) begin
      if (start) begin
        n_rdy = (wait_w != 4'd0);
      end else begin
        n_rdy = (state_q == S_WAIT);
      end
    end
  end

  assign cr_d = (sel_cr && wr && !n_rdy) ? d_in : cr_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      active_q <= 1'b0;
      a_q      <= 16'h0000;
      cr_q     <= 8'h00;
    end else begin
      active_q <= active;
      a_q      <= a;
      cr_q     <= cr_d;
      if (!active) begin
        state_q <= S_IDLE;
      end else if (start) begin
        if (wait_w >= 4'd2) begin
          state_q <= S_WAIT;
          cnt_q   <= wait_w - 4'd2;
        end else begin
          state_q <= S_DONE;
        end
      end else begin
        case (state_q)
          S_WAIT: begin
            if (cnt_q == 4'd0) begin
              state_q <= S_DONE;
            end else begin
              cnt_q <= cnt_q - 4'd1;
            end
          end
          S_DONE:  state_q <= S_DONE;
          S_IDLE:  state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_io_ctrl.sv
`default_nettype none
// == tb_io_ctrl : directed stimulus for io_ctrl against an access-level bus model -- rev 1.0 ==

module tb_io_ctrl;

  localparam int NP = 4;
  localparam int RW = 2;
  localparam int IW = 1;
  localparam int RB = 5;

  localparam int R_ROM   = 0;
  localparam int R_RAML  = 1;
  localparam int R_RAMH  = 2;
  localparam int R_CR    = 3;
  localparam int R_NONE  = 4;
  localparam int R_PORT0 = 10;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic [15:0]   a = 16'h0000;
  logic          n_oe = 1'b1;
  logic          n_we = 1'b1;
  logic [7:0]    d_in = 8'h00;
  logic [7:0]    d_out;
  logic          d_oe;
  logic          n_rdy;
  logic          n_rom_cs;
  logic          n_raml_cs;
  logic          n_ramh_cs;
  logic [NP-1:0] n_port_oe;
  logic [NP-1:0] port_cp;
  logic [7:0]    cr;

  int checks = 0;
  int errors = 0;

  io_ctrl #(
    .NUM_PORTS(NP), .ROM_WAIT(RW), .IO_WAIT(IW), .RAMH_BANKS(RB)
  ) dut (
    .clk(clk), .n_rst(n_rst), .a(a), .n_oe(n_oe), .n_we(n_we), .d_in(d_in),
    .d_out(d_out), .d_oe(d_oe), .n_rdy(n_rdy), .n_rom_cs(n_rom_cs),
    .n_raml_cs(n_raml_cs), .n_ramh_cs(n_ramh_cs), .n_port_oe(n_port_oe),
    .port_cp(port_cp), .cr(cr)
  );

  always #5 clk = ~clk;

  // Model: memory map from the address rules, wait as "cycles elapsed since access began".
  logic [7:0]  m_cr;
  logic        m_act_q;
  logic [15:0] m_a_q;
  int          m_el;

  function automatic int region(input logic [15:0] addr, input logic [7:0] c);
    int w;
    int p;
    w = int'(addr[14:12]);
    p = int'(addr[3:1]);
    if (!addr[15]) return c[0] ? R_RAML : R_ROM;
    if (w <= 1) return R_RAMH;
    if (w <= 1 + RB && c[w+1]) return R_RAMH;
    if (addr[15:8] == 8'hFF) begin
      if (p == 0) return R_CR;
      if (p <= NP) return R_PORT0 + p - 1;
    end
    return R_NONE;
  endfunction

  function automatic int wait_of(input int r);
    if (r == R_ROM) return RW;
    if (r >= R_PORT0) return IW;
    return 0;
  endfunction

  function automatic logic act_now();
    return !n_oe || !n_we;
  endfunction

  function automatic int cur_el();
    if (act_now() && (!m_act_q || a != m_a_q)) return 0;
    return m_el;
  endfunction

  function automatic logic exp_nrdy();
    return n_rst && act_now() && (cur_el() < wait_of(region(a, m_cr)));
  endfunction

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_cr    <= 8'h00;
      m_act_q <= 1'b0;
      m_a_q   <= 16'h0000;
      m_el    <= 0;
    end else begin
      if (region(a, m_cr) == R_CR && !n_we && !exp_nrdy()) m_cr <= d_in;
      m_act_q <= act_now();
      m_a_q   <= a;
      m_el    <= (cur_el() < 1000) ? cur_el() + 1 : 1000;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  logic [NP-1:0] e_oe;
  logic [NP-1:0] e_cp;
  int            e_r;
  logic          e_doe;

  always @(negedge clk) begin
    e_r  = region(a, m_cr);
    e_oe = '1;
    e_cp = '1;
    for (int i = 0; i < NP; i++) begin
      if (e_r == R_PORT0 + i && !n_we) e_cp[i] = 1'b0;
      if (e_r == R_PORT0 + i && !n_oe && n_we) e_oe[i] = 1'b0;
    end
    e_doe = (e_r == R_CR) && !n_oe && n_we;
    chk("m_n_rdy", 32'(n_rdy), 32'(exp_nrdy()));
    chk("m_cr", 32'(cr), 32'(m_cr));
    chk("m_d_oe", 32'(d_oe), 32'(e_doe));
    chk("m_d_out", 32'(d_out), e_doe ? 32'(m_cr) : 32'h0);
    chk("m_n_port_oe", 32'(n_port_oe), 32'(e_oe));
    chk("m_port_cp", 32'(port_cp), 32'(e_cp));
    if (act_now()) begin
      chk("m_n_rom_cs", 32'(n_rom_cs), 32'(e_r != R_ROM));
      chk("m_n_raml_cs", 32'(n_raml_cs), 32'(e_r != R_RAML));
      chk("m_n_ramh_cs", 32'(n_ramh_cs), 32'(e_r != R_RAMH));
    end
  end

  // Inputs change 1 after the edge; literal checks land 3 after the edge.
  task automatic drive(input logic [15:0] ad, input logic oe, input logic we, input logic [7:0] d);
    @(posedge clk);
    #1;
    a = ad; n_oe = oe; n_we = we; d_in = d;
    #2;
  endtask

  task automatic hold();
    @(posedge clk);
    #3;
  endtask

  task automatic idle();
    drive(a, 1'b1, 1'b1, 8'h00);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #3;
    chk("rst_cr", 32'(cr), 32'h00);
    chk("rst_n_rdy", 32'(n_rdy), 32'h0);
    chk("rst_rom_cs", 32'(n_rom_cs), 32'h0);
    @(posedge clk);
    #1 n_rst = 1'b1;

    drive(16'h1234, 1'b0, 1'b1, 8'h00);
    chk("rom_cs", 32'(n_rom_cs), 32'h0);
    chk("rom_w0", 32'(n_rdy), 32'h1);
    hold(); chk("rom_w1", 32'(n_rdy), 32'h1);
    hold(); chk("rom_w2", 32'(n_rdy), 32'h0);
    hold(); chk("rom_w3", 32'(n_rdy), 32'h0);
    idle();

    drive(16'hFF00, 1'b1, 1'b0, 8'h09);
    chk("crw_n_rdy", 32'(n_rdy), 32'h0);
    chk("crw_before", 32'(cr), 32'h00);
    idle();
    chk("crw_after", 32'(cr), 32'h09);
    drive(16'h1234, 1'b0, 1'b1, 8'h00);
    chk("raml_cs", 32'(n_raml_cs), 32'h0);
    chk("raml_rom_cs", 32'(n_rom_cs), 32'h1);
    chk("raml_n_rdy", 32'(n_rdy), 32'h0);
    drive(16'hA000, 1'b0, 1'b1, 8'h00);
    chk("ramh_w2_cs", 32'(n_ramh_cs), 32'h0);
    drive(16'hFF00, 1'b0, 1'b1, 8'h00);
    chk("cr_rd_doe", 32'(d_oe), 32'h1);
    chk("cr_rd_dout", 32'(d_out), 32'h09);

    drive(16'hFF00, 1'b1, 1'b0, 8'h00);
    idle();
    chk("cr_clear", 32'(cr), 32'h00);
    drive(16'hA000, 1'b0, 1'b1, 8'h00);
    chk("unm_ramh", 32'(n_ramh_cs), 32'h1);
    chk("unm_rom", 32'(n_rom_cs), 32'h1);
    chk("unm_raml", 32'(n_raml_cs), 32'h1);
    chk("unm_n_rdy", 32'(n_rdy), 32'h0);
    drive(16'h9000, 1'b0, 1'b1, 8'h00);
    chk("ramh_w1_cs", 32'(n_ramh_cs), 32'h0);
    idle();

    drive(16'hFF04, 1'b1, 1'b0, 8'h55);
    chk("p2_cp", 32'(port_cp), 32'b1101);
    chk("p2_w0", 32'(n_rdy), 32'h1);
    hold(); chk("p2_w1", 32'(n_rdy), 32'h0);
    drive(16'hFF06, 1'b1, 1'b0, 8'h55);
    chk("p3_cp", 32'(port_cp), 32'b1011);
    chk("p3_w0", 32'(n_rdy), 32'h1);
    hold(); chk("p3_w1", 32'(n_rdy), 32'h0);
    drive(16'hFF02, 1'b0, 1'b0, 8'h11);
    chk("both_cp", 32'(port_cp), 32'b1110);
    chk("both_oe", 32'(n_port_oe), 32'b1111);
    chk("both_n_rdy", 32'(n_rdy), 32'h1);
    drive(16'hFF08, 1'b0, 1'b1, 8'h00);
    chk("p4_oe", 32'(n_port_oe), 32'b0111);
    chk("p4_n_rdy", 32'(n_rdy), 32'h1);
    drive(16'hFF0A, 1'b0, 1'b1, 8'h00);
    chk("p5_oe", 32'(n_port_oe), 32'b1111);
    chk("p5_n_rdy", 32'(n_rdy), 32'h0);
    idle();

    drive(16'h1234, 1'b0, 1'b1, 8'h00);
    chk("abort_w0", 32'(n_rdy), 32'h1);
    drive(16'h1234, 1'b1, 1'b1, 8'h00);
    chk("abort_rel", 32'(n_rdy), 32'h0);
    drive(16'h1234, 1'b0, 1'b1, 8'h00);
    chk("reread_w0", 32'(n_rdy), 32'h1);
    hold(); chk("reread_w1", 32'(n_rdy), 32'h1);
    hold(); chk("reread_w2", 32'(n_rdy), 32'h0);
    idle();

    drive(16'hFF00, 1'b1, 1'b0, 8'h40);
    idle();
    chk("cr_40", 32'(cr), 32'h40);
    drive(16'h1234, 1'b0, 1'b1, 8'h00);
    hold();
    chk("pre_rst_wait", 32'(n_rdy), 32'h1);
    n_rst = 1'b0;
    #1;
    chk("async_rst_n_rdy", 32'(n_rdy), 32'h0);
    chk("async_rst_cr", 32'(cr), 32'h00);
    @(posedge clk);
    #1 n_rst = 1'b1;
    #2;
    chk("post_rst_w0", 32'(n_rdy), 32'h1);
    hold(); chk("post_rst_w1", 32'(n_rdy), 32'h1);
    hold(); chk("post_rst_w2", 32'(n_rdy), 32'h0);
    idle();
    hold();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
